// File: rtl/pdm_decimator.sv
// +--------------------------------------------------------------------------+
// | pdm_decimator : order-2 CIC decimator, 1-bit PDM stream to offset PCM     |
// | Revision 1.0 : initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module pdm_decimator #(
  parameter int BITDEPTH   = 14,
  parameter int DECIM_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pdm_in,
  output logic [BITDEPTH-1:0] pcm,
  output logic                pcm_valid
);

  localparam int W = 2*DECIM_LOG2 + 1;

  logic                  r_sync1;
  logic                  r_x;
  logic [W-1:0]          r_i1;
  logic [W-1:0]          r_i2;
  logic [W-1:0]          r_i2_prev;
  logic [W-1:0]          r_c1;
  logic [W-1:0]          r_c1_prev;
  logic [W-1:0]          r_c2;
  logic [DECIM_LOG2-1:0] r_phase;
  logic [1:0]            r_prime;
  logic                  r_v1;
  logic                  r_v2;
  logic                  w_tick;
  logic [BITDEPTH-1:0]   w_pcm;

  assign w_tick = (r_phase == {DECIM_LOG2{1'b1}});

  // The top bit of c2 set means full scale (c2 == 2**(2*DECIM_LOG2)) or above.
  assign w_pcm = r_c2[W-1] ? {BITDEPTH{1'b1}}
                           : r_c2[2*DECIM_LOG2-1 -: BITDEPTH];

  // Synchronizer, integrators and phase counter; integrators wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_x     <= 1'b0;
      r_i1    <= '0;
      r_i2    <= '0;
      r_phase <= '0;
    end else begin
      r_sync1 <= pdm_in;
      r_x     <= r_sync1;
      r_i1    <= r_i1 + W'(r_x);
      r_i2    <= r_i2 + r_i1;
      r_phase <= r_phase + DECIM_LOG2'(1);
    end
  end

  // Comb stages at the decimated rate, one pipeline edge each.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_c1      <= '0;
      r_c2      <= '0;
      r_i2_prev <= '0;
      r_c1_prev <= '0;
    end else begin
      r_v1 <= w_tick;
      r_v2 <= r_v1;
      if (w_tick) begin
        r_c1      <= r_i2 - r_i2_prev;
        r_i2_prev <= r_i2;
      end
      if (r_v1) begin
        r_c2      <= r_c1 - r_c1_prev;
        r_c1_prev <= r_c1;
      end
    end
  end

  // Output stage; the first two samples carry unprimed comb history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prime   <= 2'd0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      if (r_v2) begin
        if (r_prime == 2'd2) begin
          pcm       <= w_pcm;
          pcm_valid <= 1'b1;
        end else begin
          r_prime <= r_prime + 2'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pdm_decimator.sv
// +--------------------------------------------------------------------------+
// | tb_pdm_decimator : scoreboard bench for pdm_decimator (R = 256)           |
// | Revision 1.0 : initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pdm_decimator;

  localparam int R = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pdm_in = 1'b0;
  logic [13:0] pcm;
  logic        pcm_valid;

  pdm_decimator #(.BITDEPTH(14), .DECIM_LOG2(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pdm_in    (pdm_in),
    .pcm       (pcm),
    .pcm_valid (pcm_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp;
    int tol;
    bit care;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Pattern source: 0 const0, 1 const1, 2 toggle, 3 one-in-four, 4 sigma-delta
  int mode = 0;
  int level = 0;
  int acc = 0;
  int pc = 0;

  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        0: pdm_in = 1'b0;
        1: pdm_in = 1'b1;
        2: pdm_in = (pc % 2) == 0;
        3: pdm_in = (pc % 4) == 0;
        default: begin
          acc = acc + level;
          if (acc >= 16384) begin
            pdm_in = 1'b1;
            acc = acc - 16384;
          end else begin
            pdm_in = 1'b0;
          end
        end
      endcase
      pc++;
    end
  end

  // Monitor: pops the scoreboard on every valid, also checks timing and hold.
  int   cyc = 0;
  int   rst_edge = 0;
  int   last_valid = 0;
  bit   after_rst = 1'b1;
  bit   have_last = 1'b0;
  logic [13:0] prev_pcm = '0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        rst_edge  = cyc;
        after_rst = 1'b1;
        have_last = 1'b0;
        if (pcm !== 14'd0 || pcm_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_state: pcm=%0d valid=%b, required pcm=0 valid=0", pcm, pcm_valid);
        end
      end else if (pcm_valid !== 1'b0 && pcm_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL valid_x: pcm_valid=%b, required 0 or 1", pcm_valid);
      end else if (pcm_valid) begin
        if (after_rst) begin
          vectors++;
          if (cyc - rst_edge < 3*R - 2 || cyc - rst_edge > 3*R + 6) begin
            miscompares++;
            $display("FAIL first_valid_latency: %0d clks after reset, required %0d..%0d",
                     cyc - rst_edge, 3*R - 2, 3*R + 6);
          end
          after_rst = 1'b0;
        end else if (have_last) begin
          vectors++;
          if (cyc - last_valid != R) begin
            miscompares++;
            $display("FAIL valid_spacing: %0d clks, required %0d", cyc - last_valid, R);
          end
        end
        last_valid = cyc;
        have_last  = 1'b1;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: pcm=%0d at clk %0d, required no valid", pcm, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.care) begin
            int d;
            vectors++;
            d = int'(pcm) - e.exp;
            if (d < 0) d = -d;
            if (^pcm === 1'bx || d > e.tol) begin
              miscompares++;
              $display("FAIL pcm_value: pcm=%0d, required %0d +/- %0d", pcm, e.exp, e.tol);
            end
          end
        end
      end else if (pcm !== prev_pcm) begin
        miscompares++;
        $display("FAIL pcm_hold: pcm=%0d without valid, required %0d", pcm, prev_pcm);
      end
      prev_pcm = pcm;
    end
  end

  task automatic push(input int e, input int tol, input bit care);
    exp_t x;
    x.exp = e; x.tol = tol; x.care = care;
    sbq.push_back(x);
  endtask

  task automatic push_n(input int n, input int e);
    for (int i = 0; i < n; i++) push(e, 0, 1'b1);
  endtask

  task automatic do_reset(input int md);
    @(negedge clk);
    rst  = 1'b1;
    mode = md;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int n_samples);
    int budget;
    budget = (n_samples + 4) * R + 64;
    while (sbq.size() != 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d samples outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_cleared(input string name);
    #1;
    vectors++;
    if (pcm !== 14'd0 || pcm_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: pcm=%0d valid=%b, required pcm=0 valid=0", name, pcm, pcm_valid);
    end
  endtask

  int ramp[8] = '{0, 2048, 4160, 6144, 8256, 10240, 12352, 16320};

  initial begin
    repeat (3) @(negedge clk);
    check_cleared("power_on_reset");

    // Held 1: saturation, also long enough for the second integrator to wrap.
    do_reset(1);
    push_n(40, 16383);
    drain(42);

    do_reset(0);
    push_n(6, 0);
    drain(8);

    do_reset(2);
    push_n(6, 8192);
    drain(8);

    do_reset(3);
    push_n(6, 4096);
    drain(8);

    // Reset pulse midway between ticks.
    do_reset(2);
    push_n(10, 8192);
    drain(12);
    repeat (128) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("midway_reset");
    push_n(3, 8192);
    drain(5);

    // Reset one clk after a tick edge, with the comb pipeline in flight.
    repeat (R - 2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("inflight_reset");
    push_n(3, 8192);
    drain(5);

    // Sigma-delta staircase; level changes sit mid-window, two clean samples per step.
    level = ramp[0];
    acc   = 0;
    do_reset(4);
    for (int t = 3; t <= 32; t++) begin
      int m;
      m = (t - 1) / 4;
      push(ramp[m], 2, (t % 4 == 2) || (t % 4 == 3));
    end
    repeat (4*R - R/2) @(negedge clk);
    level = ramp[1];
    for (int m = 2; m < 8; m++) begin
      repeat (4*R) @(negedge clk);
      level = ramp[m];
    end
    drain(2);

    repeat (R) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 SHALL have parameter BITDEPTH, default 14, output PCM width (unsigned, offset-binary, matching the synth mix bus).
REQ-002 SHALL have parameter DECIM_LOG2, default 8, decimation ratio R = 2**DECIM_LOG2 (8 MHz / 256 = 31,250 Hz sample rate).
REQ-003 SHALL have port clk, input, 1, system clock (8 MHz).
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high. Clock is clk.
REQ-005 SHALL have port pdm_in, input, 1, asynchronous 1-bit pulse-density stream, e.g. a looped-back pwmout.
REQ-006 SHALL have port pcm, output, BITDEPTH, decoded sample, held between updates.
REQ-007 SHALL have port pcm_valid, output, 1, one-clk strobe marking a new pcm value.

Function
REQ-008 SHALL pass pdm_in through a 2-flop synchronizer; the 2nd flop output is x (0 or 1), and everything downstream uses only x.
REQ-009 SHALL implement an order-2 CIC: integrator widths W = 2*DECIM_LOG2+1 (17 default), both updated every clk.
REQ-010 SHALL compute i1 <= i1 + x and i2 <= i2 + i1, modulo 2**W. Wrap-around is intentional and SHALL NOT be saturated.
REQ-011 SHALL keep a DECIM_LOG2-bit phase counter, incremented every clk and wrapping R-1 -> 0.
REQ-012 SHALL assert an internal decimation tick in the cycle where phase == R-1.
REQ-013 On the tick edge, SHALL register c1 <= i2 - i2_prev (mod 2**W) and i2_prev <= i2.
REQ-014 On the next edge, SHALL register c2 <= c1 - c1_prev (mod 2**W) and c1_prev <= c1.
REQ-015 On the following edge, SHALL compute pcm from c2 and pulse pcm_valid for exactly one clk. Latency is 3 clk from the tick edge to pcm_valid high.
REQ-016 SHALL map c2 to pcm by saturating: c2 >= 2**(2*DECIM_LOG2) gives pcm = 2**BITDEPTH-1; otherwise pcm = c2 bits [2*DECIM_LOG2-1 : 2*DECIM_LOG2-BITDEPTH] (truncation, no rounding).
REQ-017 pcm_valid pulses SHALL be spaced exactly R clks apart in steady state.
REQ-018 SHALL suppress the first 2 decimated outputs after reset (comb history not primed). pcm stays 0 and pcm_valid stays low for them, via a 2-bit prime counter saturating at 2.
REQ-019 pcm SHALL change only in the cycle pcm_valid is high, and SHALL hold otherwise.
REQ-020 SHALL contain no combinational path from pdm_in to any output.

Reset
REQ-021 While rst is high at a clk edge, the following SHALL become 0: synchronizer flops, i1, i2, i2_prev, c1, c1_prev, c2, phase, prime counter, pcm and pcm_valid.
REQ-022 A reset asserted mid-operation (including while the comb pipeline is in flight) SHALL abort that sample; no pcm_valid SHALL follow from pre-reset data.
REQ-023 After rst deasserts, phase SHALL restart from 0. The first tick occurs R clks later, and the first visible pcm_valid follows the 3rd tick.

Verification
REQ-024 pdm_in held 1 from reset, R=256: first pcm_valid at clk 3*256+3 (+/-2 for sync) -> pcm = 16383; every later valid 256 clks apart, pcm = 16383 (saturation path).
REQ-025 pdm_in held 0 -> every pcm_valid carries pcm = 0; no X on outputs.
REQ-026 pdm_in toggling 1,0,1,0 each clk -> steady pcm = 8192 (c2 = 32768). A 1,0,0,0 pattern -> pcm = 4096.
REQ-027 Run 1,0 toggling for 10 samples, then pulse rst for 1 clk midway between ticks -> pcm = 0 immediately, no valid for the next 2 ticks, then pcm = 8192 again.
REQ-028 Long run (>= 2**17 clks) with pdm_in held 1 -> integrators wrap without disturbing output; pcm remains 16383 and spacing remains 256.
REQ-029 Compare against a reference model fed by a first-order sigma-delta modulator driven with a 14-bit ramp 0..16383 -> pcm tracks the ramp within +/-2 LSB after the 2-sample settle.
